ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clock-low inhibit duration (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum wait between device clock falling edges (20 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  8  command byte to send.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid && tx_ready.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse on successful completion.
REQ-009 SHALL have port tx_err  output  1  one-cycle pulse on timeout or missing ACK.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE; lets the keyboard receiver discard line activity.
REQ-011 SHALL have port ps2_clk_in  input  1  raw PS2_CLK pad level.
REQ-012 SHALL have port ps2_data_in  input  1  raw PS2_DATA pad level.
REQ-013 SHALL have port ps2_clk_oe  output  1  1 = drive PS2_CLK low; 0 = release (open-drain).
REQ-014 SHALL have port ps2_data_oe  output  1  1 = drive PS2_DATA low; 0 = release.

Function
REQ-015 SHALL synchronize ps2_clk_in and ps2_data_in through two flops; a falling edge is synchronized clk 1 then 0 on consecutive cycles.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: on handshake, latch tx_data and odd parity (~^tx_data) into a 9-bit frame; next state INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; then REQ.
REQ-019 REQ: ps2_clk_oe=1 and ps2_data_oe=1 (start bit) for one cycle; then SHIFT with ps2_clk_oe=0.
REQ-020 SHIFT: on device falling edges 1..8 drive data bit 0..7 (LSB first; oe = ~bit); on edge 9 drive parity; on edge 10 release data (stop); then ACK.
REQ-021 ACK: on falling edge 11 sample synchronized data; low = ACK; then WAIT_IDLE.
REQ-022 WAIT_IDLE: when synchronized clk and data are both high, pulse tx_done (or tx_err if ACK missing and checked), return to IDLE.
REQ-023 Timeout counter SHALL reset on entry to SHIFT and on every falling edge; reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE SHALL pulse tx_err, release both lines, return to IDLE.
REQ-024 tx_valid while busy SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=0 while asserted, counters cleared.
REQ-027 Reset mid-frame SHALL abandon the frame with no tx_done/tx_err pulse; tx_ready=1 on first cycle after release.

Configuration
REQ-028 With PS2_TX_ACK_CHECK_EN defined, data high at edge 11 SHALL produce tx_err instead of tx_done.
REQ-029 Without PS2_TX_ACK_CHECK_EN, the ACK bit SHALL be ignored and completion SHALL always produce tx_done (timeouts still produce tx_err).

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum and command constants: SET_LED 8'hED, ECHO 8'hEE, ENABLE 8'hF4, RESET 8'hFF, ACK 8'hFA, BAT_OK 8'hAA.
REQ-031 Sub-module ps2_line_sync SHALL provide the two-flop synchronizer and falling-edge detect for one line; instantiated twice.

Verification
REQ-032 tx_data=8'hED, device model clocks 11 edges, ACK low -> data bits 1,0,1,1,0,1,1,1, parity 1, one tx_done pulse, busy low after.
REQ-033 tx_data=8'h00 -> parity bit 1 driven (ps2_data_oe=0) on edge 9; tx_data=8'h01 -> parity 0 (oe=1).
REQ-034 INHIBIT_CYCLES=10: ps2_clk_oe high exactly 11 cycles (10 INHIBIT + 1 REQ); data_oe rises in REQ cycle only.
REQ-035 TIMEOUT_CYCLES=1000, device stops after edge 4 -> tx_err pulse 1000 cycles after edge 4, both oe=0, tx_ready=1.
REQ-036 ACK high at edge 11 -> tx_err with PS2_TX_ACK_CHECK_EN, tx_done without.
REQ-037 rst_n low after edge 5 -> both oe=0 same cycle, no done/err pulse; new tx_valid with 8'hF4 accepted and sent correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   state_t    - host transmit FSM states
//   CMD_*      - common PS/2 keyboard command / response bytes
//   make_frame - builds the 9-bit {odd parity, data} frame
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ACK     = 8'hFA;
    localparam logic [7:0] CMD_BAT_OK  = 8'hAA;

    // Parity bit makes the total number of ones across data+parity odd.
    function automatic logic [8:0] make_frame(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a client and the PS/2 host transmitter.
//   tx_data/tx_valid  client -> transmitter command byte and request
//   tx_ready          transmitter idle, request accepted when tx_valid && tx_ready
//   tx_done/tx_err    one-cycle completion / failure pulses
//   busy              transmitter owns the PS/2 lines
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer plus falling-edge detect for one PS/2 line.
//   clk, rst_n - system clock, async active-low reset
//   line_in    - raw pad level
//   level      - synchronized level
//   fall       - high for one cycle when the synchronized level goes 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);
    // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
    logic [2:0] sh_q, sh_d;

    always_comb sh_d = {sh_q[1:0], line_in};

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh_q <= 3'b111;
        else        sh_q <= sh_d;

    assign level = sh_q[1];
    assign fall  = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (open-drain line control).
//   clk, rst_n      - system clock, async active-low reset
//   tx              - ps2_host_tx_if.slave command handshake (data/valid/ready/done/err/busy)
//   ps2_clk_in      - raw PS2_CLK pad level
//   ps2_data_in     - raw PS2_DATA pad level
//   ps2_clk_oe      - 1 pulls PS2_CLK low
//   ps2_data_oe     - 1 pulls PS2_DATA low
// Build option: define PS2_TX_ACK_CHECK_EN to report a missing device ACK as tx_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif
    // One timer serves both the inhibit delay and the inter-edge timeout.
    localparam int TMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state_q, state_d;
    logic [8:0]    frame_q, frame_d;
    logic [3:0]    edge_q, edge_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          drive_q, drive_d;
    logic          ack_q, ack_d;

    logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
    logic tmo, line_idle, fin, tmo_err;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(ps2_clk_in),
        .level  (clk_lvl),
        .fall   (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(ps2_data_in),
        .level  (data_lvl),
        .fall   (data_fall_unused)
    );

    assign tmo       = tmr_q == TW'(TIMEOUT_CYCLES - 1);
    assign line_idle = clk_lvl && data_lvl;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            edge_q  <= '0;
            tmr_q   <= '0;
            drive_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            edge_q  <= edge_d;
            tmr_q   <= tmr_d;
            drive_q <= drive_d;
            ack_q   <= ack_d;
        end

    // Next-state: a device clock edge always takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        edge_d  = edge_q;
        tmr_d   = tmr_q + TW'(1);
        drive_d = drive_q;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (tx.tx_valid) begin
                    state_d = ST_INHIBIT;
                    frame_d = make_frame(tx.tx_data);
                end
            end
            ST_INHIBIT: if (tmr_q == TW'(INHIBIT_CYCLES - 1)) state_d = ST_REQ;
            ST_REQ: begin
                state_d = ST_SHIFT;
                tmr_d   = '0;
                edge_d  = '0;
                drive_d = 1'b1;
            end
            ST_SHIFT:
                if (clk_fall) begin
                    tmr_d  = '0;
                    edge_d = edge_q + 4'd1;
                    if (edge_q == 4'd9) begin
                        state_d = ST_ACK;
                        drive_d = 1'b0;
                    end else begin
                        drive_d = ~frame_q[edge_q];
                    end
                end else if (tmo) begin
                    state_d = ST_IDLE;
                end
            ST_ACK:
                if (clk_fall) begin
                    tmr_d   = '0;
                    ack_d   = ~data_lvl;
                    state_d = ST_WAIT_IDLE;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                end
            ST_WAIT_IDLE:
                if (line_idle)     state_d = ST_IDLE;
                else if (clk_fall) tmr_d = '0;
                else if (tmo)      state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so an async reset releases the lines at once.
    always_comb begin
        tx.tx_ready = rst_n && state_q == ST_IDLE;
        tx.busy     = state_q != ST_IDLE;
        ps2_clk_oe  = state_q == ST_INHIBIT || state_q == ST_REQ;
        ps2_data_oe = state_q == ST_REQ || (state_q == ST_SHIFT && drive_q);
        fin         = state_q == ST_WAIT_IDLE && line_idle;
        tmo_err     = (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE)
                      && !clk_fall && !fin && tmo;
        tx.tx_done  = fin && (ack_q || !ACK_CHECK);
        tx.tx_err   = tmo_err || (fin && !ack_q && ACK_CHECK);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 10;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic pad_clk, pad_data;

    int checks = 0, passed = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int cyc = 0, last_fall_cyc = 0;

    ps2_host_tx_if tx ();

    // Open-drain bus: either side may pull low.
    assign pad_clk  = ~ps2_clk_oe & dev_clk;
    assign pad_data = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx         (tx.slave),
        .ps2_clk_in (pad_clk),
        .ps2_data_in(pad_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx.tx_done) done_cnt++;
        if (tx.tx_err) err_cnt++;
        if (tx.tx_done && tx.tx_err) both_cnt++;
    end

    // Reference: bits seen on the wire after edges 1..10 = data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_bits(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic handshake(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx.tx_data = d;
        tx.tx_valid = 1'b1;
        while (!tx.tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 tx.tx_valid = 1'b0;
    endtask

    // Device: wait for the start bit, clock n edges (20 cycles each), read data on rising edges.
    task automatic dev_run(input int n_edges, input bit ack_low, output logic [9:0] bits);
        int n = 0;
        bits = 'x;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) return;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11) begin
                dev_data = ack_low ? 1'b0 : 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (10) @(negedge clk);
            if (i <= 10) bits[i-1] = pad_data;
            dev_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack_low, output logic [9:0] bits);
        handshake(d);
        dev_run(11, ack_low, bits);
        wait_idle();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({tx.tx_ready, tx.busy, tx.tx_done, tx.tx_err} !== 4'b0000) $display("FAIL reset_status got %b want 0000", {tx.tx_ready, tx.busy, tx.tx_done, tx.tx_err}); else passed++;
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); else passed++;
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tx.tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx.tx_ready); else passed++;
    endtask

    task automatic test_set_led();
        int hi = 0, first_d = -1, n = 0, d0 = done_cnt, e0 = err_cnt;
        logic [9:0] bits;
        handshake(8'hED);
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (ps2_clk_oe) hi++;
            if (ps2_data_oe && first_d < 0) first_d = hi;
            if (!ps2_clk_oe && hi > 0) break;
        end
        checks++; if (hi !== INH + 1) $display("FAIL inhibit_len got %0d want %0d", hi, INH + 1); else passed++;
        checks++; if (first_d !== INH + 1) $display("FAIL start_bit_cycle got %0d want %0d", first_d, INH + 1); else passed++;
        dev_run(11, 1'b1, bits);
        wait_idle();
        checks++; if (bits !== 10'b1_1_11101101) $display("FAIL set_led_bits got %b want %b", bits, 10'b1_1_11101101); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL set_led_done got %0d want 1", done_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL set_led_err got %0d want 0", err_cnt - e0); else passed++;
        checks++; if (tx.busy !== 1'b0) $display("FAIL set_led_busy got %b want 0", tx.busy); else passed++;
    endtask

    task automatic test_parity();
        logic [9:0] bits;
        xfer(8'h00, 1'b1, bits);
        checks++; if (bits[8] !== 1'b1) $display("FAIL parity_00 got %b want 1", bits[8]); else passed++;
        xfer(8'h01, 1'b1, bits);
        checks++; if (bits[8] !== 1'b0) $display("FAIL parity_01 got %b want 0", bits[8]); else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d = 8'($urandom);
            logic [9:0] bits;
            int d0 = done_cnt, e0 = err_cnt;
            xfer(d, 1'b1, bits);
            checks++; if (bits !== ref_bits(d)) $display("FAIL random_bits d=%h got %b want %b", d, bits, ref_bits(d)); else passed++;
            checks++; if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) $display("FAIL random_pulses d=%h done %0d err %0d want 1 0", d, done_cnt - d0, err_cnt - e0); else passed++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] d = 8'($urandom);
        logic [9:0] bits;
        int d0 = done_cnt;
        handshake(d);
        // Keep requesting with different data while the frame is in flight.
        tx.tx_data = ~d;
        tx.tx_valid = 1'b1;
        repeat (40) @(negedge clk);
        tx.tx_valid = 1'b0;
        dev_run(11, 1'b1, bits);
        wait_idle();
        repeat (20) @(negedge clk);
        checks++; if (bits !== ref_bits(d)) $display("FAIL busy_ignore_bits got %b want %b", bits, ref_bits(d)); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL busy_ignore_done got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_timeout();
        logic [9:0] bits;
        int n = 0, d0 = done_cnt, e0 = err_cnt, delta;
        handshake(8'($urandom));
        dev_run(4, 1'b1, bits);
        while (!tx.tx_err && n < 1500) begin
            @(negedge clk);
            n++;
        end
        delta = cyc - last_fall_cyc;
        // Allow up to three cycles of synchronizer and edge-detect latency.
        checks++; if (delta < TMO || delta > TMO + 3) $display("FAIL timeout_delay got %0d want %0d..%0d", delta, TMO, TMO + 3); else passed++;
        @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe, tx.tx_ready} !== 3'b001) $display("FAIL timeout_release got %b want 001", {ps2_clk_oe, ps2_data_oe, tx.tx_ready}); else passed++;
        checks++; if ({err_cnt - e0, done_cnt - d0} !== {32'd1, 32'd0}) $display("FAIL timeout_pulses err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); else passed++;
    endtask

    task automatic test_ack_high();
        logic [9:0] bits;
        int d0 = done_cnt, e0 = err_cnt;
        int exp_done, exp_err;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_done = 0; exp_err = 1;
`else
        exp_done = 1; exp_err = 0;
`endif
        xfer(8'hEE, 1'b0, bits);
        checks++; if (done_cnt - d0 !== exp_done) $display("FAIL ack_high_done got %0d want %0d", done_cnt - d0, exp_done); else passed++;
        checks++; if (err_cnt - e0 !== exp_err) $display("FAIL ack_high_err got %0d want %0d", err_cnt - e0, exp_err); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int d0 = done_cnt, e0 = err_cnt;
        handshake(8'hF4);
        dev_run(5, 1'b1, bits);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ps2_clk_oe, ps2_data_oe, tx.busy, tx.tx_ready} !== 4'b0000) $display("FAIL reset_mid_outputs got %b want 0000", {ps2_clk_oe, ps2_data_oe, tx.busy, tx.tx_ready}); else passed++;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tx.tx_ready !== 1'b1) $display("FAIL reset_mid_ready got %b want 1", tx.tx_ready); else passed++;
        repeat (30) @(negedge clk);
        checks++; if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd0}) $display("FAIL reset_mid_pulses done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); else passed++;
        d0 = done_cnt;
        xfer(8'hF4, 1'b1, bits);
        checks++; if (bits !== ref_bits(8'hF4)) $display("FAIL reset_mid_resend got %b want %b", bits, ref_bits(8'hF4)); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL reset_mid_done got %0d want 1", done_cnt - d0); else passed++;
    endtask

    initial begin
        tx.tx_data = 8'h00;
        tx.tx_valid = 1'b0;
        test_reset();
        test_set_led();
        test_parity();
        test_random();
        test_busy_ignore();
        test_timeout();
        test_ack_high();
        test_reset_mid();
        checks++; if (both_cnt !== 0) $display("FAIL done_err_overlap got %0d want 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1);
    end
endmodule
